// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: immediate format encodings and the opcodes
// that select them. Used by every immediate generator in the core.
package riscv_pkg;

  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_S     = 3'd1;
  localparam logic [2:0] IMM_B     = 3'd2;
  localparam logic [2:0] IMM_U     = 3'd3;
  localparam logic [2:0] IMM_J     = 3'd4;
  localparam logic [2:0] IMM_CSRI  = 3'd5;
  localparam logic [2:0] IMM_CSRR  = 3'd6;
  localparam logic [2:0] IMM_SHIFT = 3'd7;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational opcode/funct3 to immediate-format decoder. no_imm marks
// instructions whose immediate must read as zero (R-type and illegal).
module imm_fmt_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [2:0] sel,
  output logic       illegal,
  output logic       no_imm
);

  always_comb begin
    sel     = IMM_I;
    illegal = 1'b0;
    no_imm  = 1'b0;
    case (opcode)
      OPC_OPIMM:  sel = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHIFT : IMM_I;
      OPC_LOAD,
      OPC_JALR:   sel = IMM_I;
      OPC_STORE:  sel = IMM_S;
      OPC_BRANCH: sel = IMM_B;
      OPC_LUI,
      OPC_AUIPC:  sel = IMM_U;
      OPC_JAL:    sel = IMM_J;
      OPC_SYSTEM: begin
        if (funct3[2])
          sel = IMM_CSRI;
        else if (funct3 != 3'b000)
          sel = IMM_CSRR;
        else
          sel = IMM_I;
      end
      OPC_OP:     no_imm = 1'b1;
      default: begin
        illegal = 1'b1;
        no_imm  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: decodes the format, builds an XLEN immediate
// and holds results in a main + skid register pair behind valid/ready.
module imm_gen_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit AUTO_SEL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [2:0]      in_imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_sel,
  output logic            out_illegal
);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [2:0]      sel;
    logic            illegal;
  } entry_t;

  logic [2:0] dec_sel;
  logic       dec_illegal;
  logic       dec_no_imm;
  logic [2:0] new_sel;
  logic       new_illegal;
  logic       new_no_imm;
  entry_t     new_entry;
  entry_t     main_q, skid_q;
  logic       main_valid, skid_valid;
  logic       accept, pop;

  imm_fmt_decode u_fmt_decode (
    .opcode  (in_inst[6:0]),
    .funct3  (in_inst[14:12]),
    .sel     (dec_sel),
    .illegal (dec_illegal),
    .no_imm  (dec_no_imm)
  );

  // Every format is built at 64 bits and truncated, so one body serves both XLENs.
  function automatic logic [63:0] imm_of(input logic [2:0] sel, input logic [31:0] inst);
    logic [63:0] wide;
    case (sel)
      IMM_I:     wide = {{52{inst[31]}}, inst[31:20]};
      IMM_S:     wide = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     wide = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:     wide = {{32{inst[31]}}, inst[31:12], 12'b0};
      IMM_J:     wide = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_CSRI:  wide = {59'b0, inst[19:15]};
      IMM_SHIFT: wide = (XLEN == 64) ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
      default:   wide = '0;
    endcase
    return wide;
  endfunction

  assign new_sel     = AUTO_SEL ? dec_sel : in_imm_sel;
  assign new_illegal = AUTO_SEL ? dec_illegal : 1'b0;
  assign new_no_imm  = AUTO_SEL ? dec_no_imm : 1'b0;

  always_comb begin
    new_entry.inst    = in_inst;
    new_entry.sel     = new_sel;
    new_entry.illegal = new_illegal;
    new_entry.imm     = new_no_imm ? '0 : XLEN'(imm_of(new_sel, in_inst));
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign pop      = main_valid && out_ready;

  // Skid refills main on a pop; while main is stalled a new entry parks in skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q <= new_entry;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (main_valid) begin
        skid_q     <= new_entry;
        skid_valid <= 1'b1;
      end else begin
        main_q     <= new_entry;
        main_valid <= 1'b1;
      end
    end
  end

  assign out_valid   = main_valid;
  assign out_inst    = main_q.inst;
  assign out_imm     = main_q.imm;
  assign out_imm_sel = main_q.sel;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an XLEN=64 auto-decode instance and an XLEN=32
// explicit-select instance share stimulus and a queue-based reference model.
module tb_imm_gen_stage;

  typedef struct packed {
    logic [31:0] inst;
    logic [2:0]  sel;
  } item_t;

  typedef struct packed {
    logic [2:0]  sel;
    logic        ill;
    logic [63:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [2:0]  in_imm_sel;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_inst64;
  logic [63:0] out_imm64;
  logic [2:0]  out_imm_sel64;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_inst32;
  logic [31:0] out_imm32;
  logic [2:0]  out_imm_sel32;

  int    checks = 0;
  int    passes = 0;
  item_t q[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(64), .AUTO_SEL(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_imm_sel(in_imm_sel),
    .out_valid(out_valid64), .out_ready(out_ready), .out_inst(out_inst64),
    .out_imm(out_imm64), .out_imm_sel(out_imm_sel64), .out_illegal(out_illegal64)
  );

  imm_gen_stage #(.XLEN(32), .AUTO_SEL(1'b0)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_imm_sel(in_imm_sel),
    .out_valid(out_valid32), .out_ready(out_ready), .out_inst(out_inst32),
    .out_imm(out_imm32), .out_imm_sel(out_imm_sel32), .out_illegal(out_illegal32)
  );

  // Immediate values computed arithmetically from a signed view of the word.
  function automatic exp_t ref_model(input logic [31:0] inst, input logic [2:0] sel_in,
                                     input int xlen, input bit auto_sel);
    exp_t       r;
    int signed  s;
    longint     v;
    bit         zero;
    logic [2:0] f3;
    s    = inst;
    f3   = inst[14:12];
    zero = 1'b0;
    r.sel = sel_in;
    r.ill = 1'b0;
    if (auto_sel) begin
      case (inst[6:0])
        7'h13:        r.sel = (f3 == 3'd1 || f3 == 3'd5) ? 3'd7 : 3'd0;
        7'h03, 7'h67: r.sel = 3'd0;
        7'h23:        r.sel = 3'd1;
        7'h63:        r.sel = 3'd2;
        7'h37, 7'h17: r.sel = 3'd3;
        7'h6f:        r.sel = 3'd4;
        7'h73:        r.sel = f3[2] ? 3'd5 : ((f3 == 3'd0) ? 3'd0 : 3'd6);
        7'h33: begin r.sel = 3'd0; zero = 1'b1; end
        default: begin r.sel = 3'd0; r.ill = 1'b1; zero = 1'b1; end
      endcase
    end
    case (r.sel)
      3'd0: v = longint'(s >>> 20);
      3'd1: v = (longint'(s >>> 25) <<< 5) | longint'(inst[11:7]);
      3'd2: v = (longint'(s >>> 31) <<< 12) | (longint'(inst[7]) << 11)
              | (longint'(inst[30:25]) << 5) | (longint'(inst[11:8]) << 1);
      3'd3: v = longint'(s >>> 12) * 4096;
      3'd4: v = (longint'(s >>> 31) <<< 20) | (longint'(inst[19:12]) << 12)
              | (longint'(inst[20]) << 11) | (longint'(inst[30:21]) << 1);
      3'd5: v = longint'(inst[19:15]);
      3'd7: v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
      default: v = 0;
    endcase
    if (zero) v = 0;
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    r.imm = v;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkOutput();
    exp_t e64, e32;
    check("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    check("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
    check("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
    check("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
    if (q.size() > 0) begin
      e64 = ref_model(q[0].inst, q[0].sel, 64, 1'b1);
      e32 = ref_model(q[0].inst, q[0].sel, 32, 1'b0);
      check("out_inst64", 64'(out_inst64), 64'(q[0].inst));
      check("out_imm64", out_imm64, e64.imm);
      check("out_sel64", 64'(out_imm_sel64), 64'(e64.sel));
      check("out_ill64", 64'(out_illegal64), 64'(e64.ill));
      check("out_inst32", 64'(out_inst32), 64'(q[0].inst));
      check("out_imm32", 64'(out_imm32), e32.imm);
      check("out_sel32", 64'(out_imm_sel32), 64'(e32.sel));
      check("out_ill32", 64'(out_illegal32), 64'(e32.ill));
    end
  endtask

  // One clock: drive, compare at the falling edge, advance the model, step.
  task automatic applyStimulus(input bit v, input logic [31:0] inst, input logic [2:0] sel,
                               input bit ordy, input bit fl);
    bit    acc, pp;
    item_t it;
    in_valid   = v;
    in_inst    = inst;
    in_imm_sel = sel;
    out_ready  = ordy;
    flush      = fl;
    @(negedge clk);
    checkOutput();
    acc = v && (q.size() < 2);
    pp  = (q.size() > 0) && ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        it.inst = inst;
        it.sel  = sel;
        q.push_back(it);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opcs[12];
    logic [31:0] w;
    opcs = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73, 7'h33, 7'h7f, 7'h0b};
    w = $urandom;
    w[6:0] = opcs[$urandom % 12];
    return w;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_imm_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid64), 64'd0);
    check("rst_in_ready", 64'(in_ready64), 64'd1);
    check("rst_out_inst", 64'(out_inst64), 64'd0);
    check("rst_out_imm", out_imm64, 64'd0);
    check("rst_out_sel", 64'(out_imm_sel64), 64'd0);
    check("rst_out_ill", 64'(out_illegal64), 64'd0);
    check("rst_out_imm32", 64'(out_imm32), 64'd0);

    applyStimulus(1'b1, 32'hFFF0_0093, 3'd0, 1'b1, 1'b0);
    check("addi_valid", 64'(out_valid64), 64'd1);
    check("addi_sel", 64'(out_imm_sel64), 64'd0);
    check("addi_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_imm32", 64'(out_imm32), 64'hFFFF_FFFF);

    applyStimulus(1'b1, 32'h8000_0537, 3'd3, 1'b1, 1'b0);
    check("lui_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    check("lui_imm32", 64'(out_imm32), 64'h8000_0000);
    applyStimulus(1'b1, 32'h00C0_006F, 3'd4, 1'b1, 1'b0);
    check("jal_imm64", out_imm64, 64'h0000_000C);
    check("jal_in_ready", 64'(in_ready64), 64'd1);
    applyStimulus(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h0010_0093, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0020_0113, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0030_0193, 3'd0, 1'b0, 1'b0);
    check("bp_in_ready", 64'(in_ready64), 64'd0);
    check("bp_hold_inst", 64'(out_inst64), 64'h0010_0093);
    repeat (3) applyStimulus(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h0040_0213, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0050_0293, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0060_0313, 3'd0, 1'b0, 1'b1);
    check("flush_out_valid", 64'(out_valid64), 64'd0);
    check("flush_in_ready", 64'(in_ready64), 64'd1);
    applyStimulus(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h3401_D073, 3'd5, 1'b1, 1'b0);
    check("csrrwi_sel", 64'(out_imm_sel64), 64'd5);
    check("csrrwi_imm", out_imm64, 64'd3);
    applyStimulus(1'b1, 32'h3405_1073, 3'd6, 1'b1, 1'b0);
    check("csrrw_sel", 64'(out_imm_sel64), 64'd6);
    check("csrrw_imm", out_imm64, 64'd0);
    applyStimulus(1'b1, 32'h0210_9093, 3'd7, 1'b1, 1'b0);
    check("slli_sel", 64'(out_imm_sel64), 64'd7);
    check("slli_imm", out_imm64, 64'd33);
    applyStimulus(1'b1, 32'hFE00_0EE3, 3'd2, 1'b1, 1'b0);
    check("beq_sel", 64'(out_imm_sel64), 64'd2);
    check("beq_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b1, 32'h0000_007F, 3'd0, 1'b1, 1'b0);
    check("illegal_flag", 64'(out_illegal64), 64'd1);
    check("illegal_imm", out_imm64, 64'd0);
    applyStimulus(1'b1, 32'h0011_2423, 3'd1, 1'b1, 1'b0);
    check("sw_manual_imm32", 64'(out_imm32), 64'd8);
    check("sw_manual_sel32", 64'(out_imm_sel32), 64'd1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, rand_inst(), 3'($urandom), ($urandom % 3) != 0,
                    ($urandom % 25) == 0);
    end
    repeat (4) applyStimulus(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
